// File: rtl/reset_pkg.sv
// Shared types and helpers for the reset controller and its button debouncer.
package reset_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RUN     = 2'd1,
      TRAPPED = 2'd2
   } reset_state_t;

   typedef enum logic [1:0] {
      CAUSE_POR    = 2'd0,
      CAUSE_BUTTON = 2'd1,
      CAUSE_TRAP   = 2'd2
   } reset_cause_t;

   localparam logic [7:0] COUNT_MAX = 8'd255;

   // Width of a down/up counter that must hold values 0 .. n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Restart counter increment that sticks at its maximum.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      if (v == COUNT_MAX) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

endpackage

// File: rtl/reset_controller_debounce.sv
// Button conditioning: two-flop synchronizer followed by a stability filter.
// The debounced level only flips after the synchronized level has disagreed
// with it for CYCLES consecutive clocks.
module debounce
   import reset_pkg::*;
#(
   parameter int CYCLES = 20000
) (
   input  logic clk,
   input  logic power_on_reset,
   input  logic in_n,
   output logic pressed
);

   localparam int            CW       = cnt_width(CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pressed_q, pressed_d;
   logic          pressed_raw_s;

   assign pressed_raw_s = ~sync2_q;
   assign pressed       = pressed_q;

   // Next-state for the synchronizer chain and the stability counter.
   always_comb begin
      sync1_d   = in_n;
      sync2_d   = sync1_q;
      cnt_d     = '0;
      pressed_d = pressed_q;
      if (pressed_raw_s == pressed_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         pressed_d = pressed_raw_s;
         cnt_d     = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Registers; reset leaves the button seen as released.
   always_ff @(posedge clk or posedge power_on_reset) begin
      if (power_on_reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         cnt_q     <= '0;
         pressed_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
      end
   end

endmodule

// File: rtl/reset_controller.sv
// Core reset sequencer: stretches reset after power-on and button presses,
// and restarts (or parks) the core after a trap. Reports last cause and a
// saturating count of non-power-on resets.
module reset_controller
   import reset_pkg::*;
#(
   parameter int DEBOUNCECYCLES = 20000,
   parameter int HOLDCYCLES     = 16,
   parameter int TRAPWAITCYCLES = 2000000,
   parameter int AUTORESTART    = 1
) (
   input  logic       clk,
   input  logic       power_on_reset,
   input  logic       btn_n,
   input  logic       trap,
   output logic       system_reset,
   output logic       trapped,
   output logic [1:0] reset_cause,
   output logic [7:0] reset_count
);

   localparam int            HW        = cnt_width(HOLDCYCLES);
   localparam int            TW        = cnt_width(TRAPWAITCYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDCYCLES - 1);
   localparam logic [TW-1:0] TRAP_LAST = TW'(TRAPWAITCYCLES - 1);

   reset_state_t  state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [TW-1:0] trap_cnt_q, trap_cnt_d;
   reset_cause_t  cause_q, cause_d;
   logic [7:0]    count_q, count_d;
   logic          system_reset_q, system_reset_d;
   logic          trapped_q, trapped_d;
   logic          pressed_s;

   debounce #(.CYCLES(DEBOUNCECYCLES)) u_debounce (
      .clk            (clk),
      .power_on_reset (power_on_reset),
      .in_n           (btn_n),
      .pressed        (pressed_s)
   );

   assign system_reset = system_reset_q;
   assign trapped      = trapped_q;
   assign reset_cause  = cause_q;
   assign reset_count  = count_q;

   // Next-state, counters and registered outputs derived from the next state.
   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      trap_cnt_d = trap_cnt_q;
      cause_d    = cause_q;
      count_d    = count_q;
      case (state_q)
         HOLD: begin
            if (pressed_s) begin
               hold_d = HOLD_LAST;
            end else if (hold_q == '0) begin
               state_d = RUN;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         RUN: begin
            if (pressed_s) begin
               state_d = HOLD;
               hold_d  = HOLD_LAST;
               cause_d = CAUSE_BUTTON;
               count_d = sat_inc(count_q);
            end else if (trap) begin
               state_d    = TRAPPED;
               trap_cnt_d = TRAP_LAST;
            end else begin
               state_d = RUN;
            end
         end
         TRAPPED: begin
            if (pressed_s) begin
               state_d = HOLD;
               hold_d  = HOLD_LAST;
               cause_d = CAUSE_BUTTON;
               count_d = sat_inc(count_q);
            end else if (AUTORESTART != 0) begin
               if (trap_cnt_q == '0) begin
                  state_d = HOLD;
                  hold_d  = HOLD_LAST;
                  cause_d = CAUSE_TRAP;
                  count_d = sat_inc(count_q);
               end else begin
                  trap_cnt_d = trap_cnt_q - TW'(1);
               end
            end else begin
               trap_cnt_d = trap_cnt_q;
            end
         end
         default: begin
            state_d = HOLD;
            hold_d  = HOLD_LAST;
         end
      endcase
      system_reset_d = (state_d == HOLD);
      trapped_d      = (state_d == TRAPPED);
   end

   // State, counter and output registers; power-on reset forces reset values.
   always_ff @(posedge clk or posedge power_on_reset) begin
      if (power_on_reset) begin
         state_q        <= HOLD;
         hold_q         <= HOLD_LAST;
         trap_cnt_q     <= '0;
         cause_q        <= CAUSE_POR;
         count_q        <= 8'd0;
         system_reset_q <= 1'b1;
         trapped_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         hold_q         <= hold_d;
         trap_cnt_q     <= trap_cnt_d;
         cause_q        <= cause_d;
         count_q        <= count_d;
         system_reset_q <= system_reset_d;
         trapped_q      <= trapped_d;
      end
   end

endmodule
